// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage register file bus: two read ports, one write port, clear request.
// Latency: reads combinational, writes land on the next clk edge.
// Backpressure: ready low means writes are ignored and reads return zero.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF
);
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] qs;
    logic [DATA_W-1:0] qt;
    logic              ready;

    modport master (output clr, we, rs, rt, rd, d, input qs, qt, ready);
    modport slave  (input clr, we, rs, rt, rd, d, output qs, qt, ready);
endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on clr, then holds ready.
// Latency: ready rises 2**ADDR_W edges after rst release or a clr edge.
// Backpressure: clr restarts the sweep from entry 0 in any state.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic [ADDR_W-1:0] cnt,
    output logic              sweep_we,
    output logic              ready
);
    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        if (clr) begin
            state_nxt = RF_CLEAR;
            cnt_nxt   = '0;
        end else if (state == RF_CLEAR) begin
            sweep_we = 1'b1;
            cnt_nxt  = cnt + 1'b1;
            // last entry: all-ones index, counter wraps back to 0 on the same edge
            if (&cnt) state_nxt = RF_READY;
        end
    end

    assign ready = (state == RF_READY);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised 2R1W register file with sweep clear; REGFILE_BYPASS_EN adds write-through.
// Latency: combinational reads, write visible next cycle (same cycle with bypass).
// Backpressure: while ready is low writes are dropped and qs/qt read zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] rf [DEPTH];
    logic [ADDR_W-1:0] cnt;
    logic              sweep_we;
    logic              ready;
    logic              user_we;
    logic [DATA_W-1:0] qs_val;
    logic [DATA_W-1:0] qt_val;

    regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.clr),
        .cnt      (cnt),
        .sweep_we (sweep_we),
        .ready    (ready)
    );

    assign user_we = ready && bus.we && !bus.clr && !(ZR && (bus.rd == '0));

    // No reset on the array so it can map to distributed RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            rf[cnt] <= '0;
        end else if (user_we) begin
            rf[bus.rd] <= bus.d;
        end
    end

    always_comb begin
        qs_val = rf[bus.rs];
        qt_val = rf[bus.rt];
`ifdef REGFILE_BYPASS_EN
        if (user_we && (bus.rd == bus.rs)) qs_val = bus.d;
        if (user_we && (bus.rd == bus.rt)) qt_val = bus.d;
`endif
        if (!ready || (ZR && (bus.rs == '0))) qs_val = '0;
        if (!ready || (ZR && (bus.rt == '0))) qt_val = '0;
    end

    assign bus.qs    = qs_val;
    assign bus.qt    = qt_val;
    assign bus.ready = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32 with zero register, plus an 8x16 instance without it.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut16 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus0.clr = 0; bus0.we = 0; bus0.rs = 5'd3; bus0.rt = 5'd7; bus0.rd = 0; bus0.d = 0;
        bus1.clr = 0; bus1.we = 0; bus1.rs = 3'd1; bus1.rt = 3'd2; bus1.rd = 0; bus1.d = 0;
        #2;
        checks++;
        if (bus0.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus0.ready); end
        checks++;
        if (bus0.qs !== 32'h0 || bus0.qt !== 32'h0) begin
            errors++; $display("FAIL reset_q: got qs=%h qt=%h want 0", bus0.qs, bus0.qt);
        end
        checks++;
        if (bus1.ready !== 1'b0) begin errors++; $display("FAIL reset_ready16: got %b want 0", bus1.ready); end
    endtask

    task automatic test_sweep;
        int n;
        int nz;
        n = 0; nz = 0;
        tick;
        bus0.we = 1; bus0.rd = 5'd3; bus0.d = 32'hDEAD; bus0.rs = 5'd3; bus0.rt = 5'd3;
        rst0 = 0;
        while (n < 100) begin
            tick;
            n++;
            if (bus0.ready === 1'b1) break;
            if (bus0.qs !== 32'h0 || bus0.qt !== 32'h0) nz++;
        end
        bus0.we = 0;
        checks++;
        if (n != 32) begin errors++; $display("FAIL sweep_len: got %0d edges want 32", n); end
        checks++;
        if (nz != 0) begin errors++; $display("FAIL sweep_qmask: got %0d nonzero cycles want 0", nz); end
        #1;
        checks++;
        if (bus0.qs !== 32'h0) begin errors++; $display("FAIL sweep_we_ignored: got %h want 0", bus0.qs); end
    endtask

    task automatic test_write_read;
        logic [31:0] exp_wc;
`ifdef REGFILE_BYPASS_EN
        exp_wc = 32'h1234_5678;
`else
        exp_wc = 32'h0;
`endif
        bus0.we = 1; bus0.rd = 5'd5; bus0.d = 32'h1234_5678; bus0.rs = 5'd5; bus0.rt = 5'd5;
        #1;
        checks++;
        if (bus0.qs !== exp_wc || bus0.qt !== exp_wc) begin
            errors++; $display("FAIL wr_same_cycle: got qs=%h qt=%h want %h", bus0.qs, bus0.qt, exp_wc);
        end
        tick;
        bus0.we = 0;
        #1;
        checks++;
        if (bus0.qs !== 32'h1234_5678 || bus0.qt !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_next_cycle: got qs=%h qt=%h want 12345678", bus0.qs, bus0.qt);
        end
        bus0.rt = 5'd4;
        #1;
        checks++;
        if (bus0.qt !== 32'h0) begin errors++; $display("FAIL wr_other_addr: got %h want 0", bus0.qt); end
    endtask

    task automatic test_zero_reg;
        bus0.we = 1; bus0.rd = 5'd0; bus0.d = 32'hFFFF_FFFF; bus0.rs = 5'd0; bus0.rt = 5'd0;
        #1;
        checks++;
        if (bus0.qs !== 32'h0) begin errors++; $display("FAIL zero_same_cycle: got %h want 0", bus0.qs); end
        tick;
        bus0.we = 0;
        #1;
        checks++;
        if (bus0.qs !== 32'h0 || bus0.qt !== 32'h0) begin
            errors++; $display("FAIL zero_reg: got qs=%h qt=%h want 0", bus0.qs, bus0.qt);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_s;
        logic [31:0] exp_t;
        for (int i = 0; i < 4; i++) begin
            bus0.we = 1; bus0.rd = 5'(10 + i); bus0.d = 32'hB000_0000 + 32'(i);
            bus0.rs = 5'(10 + i); bus0.rt = 5'(9 + i);
`ifdef REGFILE_BYPASS_EN
            exp_s = 32'hB000_0000 + 32'(i);
`else
            exp_s = 32'h0;
`endif
            exp_t = (i == 0) ? 32'h0 : 32'hB000_0000 + 32'(i - 1);
            #1;
            checks++;
            if (bus0.qs !== exp_s || bus0.qt !== exp_t) begin
                errors++;
                $display("FAIL b2b_%0d: got qs=%h qt=%h want qs=%h qt=%h", i, bus0.qs, bus0.qt, exp_s, exp_t);
            end
            tick;
        end
        bus0.we = 0;
    endtask

    task automatic test_clr;
        int n;
        int bad;
        n = 0; bad = 0;
        for (int i = 1; i < 32; i++) begin
            bus0.we = 1; bus0.rd = 5'(i); bus0.d = 32'(i);
            tick;
        end
        bus0.we = 0; bus0.rs = 5'd7; bus0.rt = 5'd31;
        #1;
        checks++;
        if (bus0.qs !== 32'd7 || bus0.qt !== 32'd31) begin
            errors++; $display("FAIL clr_fill: got qs=%h qt=%h want 7/31", bus0.qs, bus0.qt);
        end
        bus0.clr = 1; bus0.we = 1; bus0.rd = 5'd7; bus0.d = 32'd99;
        tick;
        bus0.clr = 0; bus0.we = 0;
        checks++;
        if (bus0.ready !== 1'b0 || bus0.qs !== 32'h0) begin
            errors++; $display("FAIL clr_drop: got ready=%b qs=%h want 0/0", bus0.ready, bus0.qs);
        end
        while (n < 100) begin
            tick;
            n++;
            if (bus0.ready === 1'b1) break;
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL clr_sweep_len: got %0d edges want 32", n); end
        for (int i = 0; i < 32; i++) begin
            bus0.rs = 5'(i); bus0.rt = 5'(31 - i);
            #1;
            if (bus0.qs !== 32'h0 || bus0.qt !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clr_all_zero: got %0d nonzero reads want 0", bad); end
    endtask

    task automatic test_async_rst;
        int n;
        n = 0;
        tick;
        bus0.we = 1; bus0.rd = 5'd9; bus0.d = 32'hAAAA_5555; bus0.rs = 5'd9; bus0.rt = 5'd9;
        tick;
        bus0.we = 0;
        checks++;
        if (bus0.qs !== 32'hAAAA_5555) begin errors++; $display("FAIL arst_pre: got %h want aaaa5555", bus0.qs); end
        #2 rst0 = 1;
        #1;
        checks++;
        if (bus0.ready !== 1'b0 || bus0.qs !== 32'h0) begin
            errors++; $display("FAIL arst_ready_drop: got ready=%b qs=%h want 0/0", bus0.ready, bus0.qs);
        end
        rst0 = 0;
        for (int i = 0; i < 17; i++) tick;
        #2 rst0 = 1;
        #1;
        checks++;
        if (bus0.ready !== 1'b0) begin errors++; $display("FAIL arst_mid_sweep: got ready=%b want 0", bus0.ready); end
        tick;
        rst0 = 0;
        while (n < 100) begin
            tick;
            n++;
            if (bus0.ready === 1'b1) break;
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL arst_restart_len: got %0d edges want 32", n); end
    endtask

    task automatic test_param;
        int n;
        int bad;
        logic [15:0] exp_v;
        n = 0; bad = 0;
        rst1 = 0;
        while (n < 100) begin
            tick;
            n++;
            if (bus1.ready === 1'b1) break;
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL p16_sweep_len: got %0d edges want 8", n); end
        for (int i = 0; i < 8; i++) begin
            bus1.we = 1; bus1.rd = 3'(i);
            bus1.d = (i == 0) ? 16'hFFFF : 16'h1111 * 16'(i);
            tick;
        end
        bus1.we = 0;
        bus1.rs = 3'd0; bus1.rt = 3'd0;
        #1;
        checks++;
        if (bus1.qs !== 16'hFFFF || bus1.qt !== 16'hFFFF) begin
            errors++; $display("FAIL p16_no_zero_reg: got qs=%h qt=%h want ffff", bus1.qs, bus1.qt);
        end
        for (int i = 1; i < 8; i++) begin
            bus1.rs = 3'(i); bus1.rt = 3'(i);
            exp_v = 16'h1111 * 16'(i);
            #1;
            if (bus1.qs !== exp_v || bus1.qt !== exp_v) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL p16_readback: got %0d wrong reads want 0", bad); end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_write_read;
        test_zero_reg;
        test_back_to_back;
        test_clr;
        test_async_rst;
        test_param;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
